// File: rtl/scaler_readout_sequencer.sv
// Gate/snapshot/readout sequencer for a bank of scaler counters: times a gate,
// snapshots all channel counts into a shadow bank and streams them out one per beat.
module scaler_readout_sequencer #(
  parameter int NUMBER_OF_CHANNELS         = 8,
  parameter int REGISTER_WIDTH             = 32,
  parameter int LOG2_OF_NUMBER_OF_CHANNELS = $clog2(NUMBER_OF_CHANNELS)
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         continuous,
  input  logic                                         stop,
  input  logic [31:0]                                  gate_periods,
  input  logic [NUMBER_OF_CHANNELS*REGISTER_WIDTH-1:0] counts_in,
  output logic                                         counter_reset,
  output logic [REGISTER_WIDTH-1:0]                    out_data,
  output logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0]        out_channel,
  output logic [15:0]                                  out_frame,
  output logic                                         out_last,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         busy,
  output logic                                         overrun,
  output logic [15:0]                                  dropped_frames,
  output logic [1:0]                                   gate_state,
  output logic                                         readout_state
);

  localparam logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] LAST_CH =
    LOG2_OF_NUMBER_OF_CHANNELS'(NUMBER_OF_CHANNELS - 1);

  typedef enum logic [1:0] {G_IDLE, G_CLEAR, G_GATE, G_SNAP} gate_t;
  typedef enum logic       {R_EMPTY, R_SEND} rd_t;

  gate_t g_state, g_next;
  rd_t   r_state, r_next;

  logic [31:0]                           gate_len;
  logic [31:0]                           gate_cnt;
  logic                                  cont_flag;
  logic [REGISTER_WIDTH-1:0]             shadow [NUMBER_OF_CHANNELS];
  logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] ch;
  logic [15:0]                           frame_cnt;
  logic [15:0]                           frame_out;
  logic                                  accept;
  logic                                  last_accept;
  logic                                  load;
  logic                                  drop;

  // Stream handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, every
  // out_* field is held because the shadow bank and ch only move on a transfer.
  assign out_valid     = (r_state == R_SEND);
  assign out_last      = out_valid && (ch == LAST_CH);
  assign out_data      = shadow[ch];
  assign out_channel   = ch;
  assign out_frame     = frame_out;
  assign accept        = out_valid && out_ready;
  assign last_accept   = accept && out_last;
  assign counter_reset = (g_state == G_IDLE) || (g_state == G_CLEAR);
  assign busy          = (g_state != G_IDLE) || (r_state != R_EMPTY);
  assign gate_state    = g_state;
  assign readout_state = r_state;

  // The shadow bank may be overwritten only once its previous frame is fully drained.
  assign load = (g_state == G_SNAP) && ((r_state == R_EMPTY) || last_accept);
  assign drop = (g_state == G_SNAP) && !load;

  always_comb begin
    g_next = g_state;
    case (g_state)
      G_IDLE:  if (start) g_next = G_CLEAR;
      G_CLEAR: g_next = G_GATE;
      G_GATE:  if (gate_cnt == gate_len - 32'd1) g_next = G_SNAP;
      G_SNAP:  g_next = cont_flag ? G_CLEAR : G_IDLE;
      default: g_next = G_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    if (load)             r_next = R_SEND;
    else if (last_accept) r_next = R_EMPTY;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      g_state        <= G_IDLE;
      r_state        <= R_EMPTY;
      gate_len       <= 32'd1;
      gate_cnt       <= '0;
      cont_flag      <= 1'b0;
      ch             <= '0;
      frame_cnt      <= '0;
      frame_out      <= '0;
      overrun        <= 1'b0;
      dropped_frames <= '0;
      for (int k = 0; k < NUMBER_OF_CHANNELS; k++) shadow[k] <= '0;
    end else begin
      g_state <= g_next;
      r_state <= r_next;

      // Start wins over a simultaneous stop, but that stop still cancels continuous mode.
      if ((g_state == G_IDLE) && start) begin
        gate_len  <= (gate_periods == 32'd0) ? 32'd1 : gate_periods;
        cont_flag <= continuous && !stop;
      end else if (stop) begin
        cont_flag <= 1'b0;
      end

      gate_cnt <= (g_state == G_GATE) ? gate_cnt + 32'd1 : 32'd0;

      if (load) begin
        for (int k = 0; k < NUMBER_OF_CHANNELS; k++)
          shadow[k] <= counts_in[k*REGISTER_WIDTH +: REGISTER_WIDTH];
        frame_out <= frame_cnt;
        frame_cnt <= frame_cnt + 16'd1;
        ch        <= '0;
      end else if (accept) begin
        ch <= out_last ? '0 : ch + 1'b1;
      end

      if (drop) begin
        overrun <= 1'b1;
        if (dropped_frames != 16'hffff) dropped_frames <= dropped_frames + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_scaler_readout_sequencer.sv
// Bench for scaler_readout_sequencer (4 channels x 32 bits): directed scenarios
// plus randomized traffic checked against a timeline/queue reference model.
module tb_scaler_readout_sequencer;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BW = 16 + 2 + 1 + W;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           continuous = 1'b0;
  logic           stop = 1'b0;
  logic [31:0]    gate_periods = 32'd0;
  logic [N*W-1:0] counts_in = '0;
  logic           counter_reset;
  logic [W-1:0]   out_data;
  logic [1:0]     out_channel;
  logic [15:0]    out_frame;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           overrun;
  logic [15:0]    dropped_frames;
  logic [1:0]     gate_state;
  logic           readout_state;

  int n_vec  = 0;
  int n_miss = 0;

  scaler_readout_sequencer #(
    .NUMBER_OF_CHANNELS(N),
    .REGISTER_WIDTH(W),
    .LOG2_OF_NUMBER_OF_CHANNELS(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .stop(stop), .gate_periods(gate_periods), .counts_in(counts_in),
    .counter_reset(counter_reset), .out_data(out_data), .out_channel(out_channel),
    .out_frame(out_frame), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun),
    .dropped_frames(dropped_frames), .gate_state(gate_state),
    .readout_state(readout_state)
  );

  always #5 clock = ~clock;

  // Reference model: gate activity is a timeline (CLEAR cycle, SNAP cycle);
  // readout is a queue of pending beats {frame, channel, last, data}.
  logic [BW-1:0] exp_q[$];
  bit            armed = 0;
  bit            m_gate_busy = 0;
  bit            m_cont = 0;
  bit            m_over = 0;
  int            m_gl = 1;
  int            m_clear = 0;
  int            m_snap = 0;
  int            cyc = 0;
  logic [15:0]   m_frame = '0;
  logic [15:0]   m_drop = '0;

  always @(negedge clock) begin
    logic [BW-1:0] f;
    bit acc, ld, was_busy, exp_busy, exp_cr;
    cyc++;
    if (armed) begin
      exp_busy = m_gate_busy || (exp_q.size() != 0);
      exp_cr   = !(m_gate_busy && (cyc > m_clear));
      n_vec++;
      if (busy !== exp_busy) begin
        n_miss++; $display("FAIL model_busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
      end
      n_vec++;
      if (counter_reset !== exp_cr) begin
        n_miss++; $display("FAIL model_counter_reset cyc=%0d got %b want %b", cyc, counter_reset, exp_cr);
      end
      n_vec++;
      if ({overrun, dropped_frames} !== {m_over, m_drop}) begin
        n_miss++; $display("FAIL model_overrun cyc=%0d got %b/%0d want %b/%0d",
                           cyc, overrun, dropped_frames, m_over, m_drop);
      end
      n_vec++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_miss++; $display("FAIL model_valid cyc=%0d got %b want %b", cyc, out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        f = exp_q[0];
        n_vec++;
        if ({out_frame, out_channel, out_last, out_data} !== f) begin
          n_miss++; $display("FAIL model_beat cyc=%0d got f%0d c%0d l%b d%h want f%0d c%0d l%b d%h",
                             cyc, out_frame, out_channel, out_last, out_data,
                             f[BW-1 -: 16], f[W+2 -: 2], f[W], f[W-1:0]);
        end
      end
    end
    if (reset) begin
      exp_q.delete();
      m_gate_busy = 0; m_cont = 0; m_over = 0; m_frame = '0; m_drop = '0;
      armed = 1;
    end else if (armed) begin
      acc      = (exp_q.size() != 0) && (out_ready === 1'b1);
      was_busy = m_gate_busy;
      if (m_gate_busy && (cyc == m_snap)) begin
        ld = (exp_q.size() == 0) || ((exp_q.size() == 1) && acc);
        if (acc) void'(exp_q.pop_front());
        if (ld) begin
          for (int k = 0; k < N; k++)
            exp_q.push_back({m_frame, 2'(k), (k == N-1) ? 1'b1 : 1'b0, counts_in[k*W +: W]});
          m_frame++;
        end else begin
          m_over = 1;
          if (m_drop != 16'hffff) m_drop++;
        end
        if (m_cont) begin
          m_clear = cyc + 1; m_snap = cyc + 2 + m_gl;
        end else begin
          m_gate_busy = 0;
        end
      end else if (acc) begin
        void'(exp_q.pop_front());
      end
      if (!was_busy && start) begin
        m_gate_busy = 1;
        m_gl    = (gate_periods == 0) ? 1 : int'(gate_periods);
        m_cont  = continuous && !stop;
        m_clear = cyc + 1;
        m_snap  = cyc + 2 + m_gl;
      end else if (stop) begin
        m_cont = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; start = 0; stop = 0; continuous = 0; out_ready = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1;
    @(posedge clock); #1 start = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin done = 1; break; end
    end
    n_vec++;
    if (!done) begin n_miss++; $display("FAIL wait_idle busy=%b after %0d cycles, want 0", busy, budget); end
  endtask

  // Issues stop in the second GATE cycle, well clear of SNAP for gates of 2+ cycles.
  task automatic send_stop();
    bit prev_cr = 0, found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (prev_cr && (counter_reset === 1'b0)) begin found = 1; break; end
      prev_cr = counter_reset;
    end
    n_vec++;
    if (!found) begin n_miss++; $display("FAIL send_stop no gate entry seen, got 0 want 1"); end
    @(posedge clock); #1 stop = 1;
    @(posedge clock); #1 stop = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_vec++;
    if ({counter_reset, out_valid, out_last, busy, overrun} !== 5'b10000) begin
      n_miss++; $display("FAIL reset_flags got cr%b v%b l%b b%b o%b want 1 0 0 0 0",
                         counter_reset, out_valid, out_last, busy, overrun);
    end
    n_vec++;
    if ({out_data, out_channel, out_frame, dropped_frames} !== '0) begin
      n_miss++; $display("FAIL reset_values got d%h c%0d f%0d drop%0d want all 0",
                         out_data, out_channel, out_frame, dropped_frames);
    end
  endtask

  task automatic test_basic();
    bit ev, ecr, eb;
    do_reset();
    counts_in = {32'd40, 32'd30, 32'd20, 32'd10};
    gate_periods = 32'd10; out_ready = 1;
    pulse_start();
    for (int c = 1; c <= 17; c++) begin
      @(negedge clock);
      ev  = (c >= 13) && (c <= 16);
      ecr = (c == 1) || (c >= 13);
      eb  = (c <= 16);
      n_vec++;
      if ({out_valid, counter_reset, busy} !== {ev, ecr, eb}) begin
        n_miss++; $display("FAIL basic_timing c%0d got v%b cr%b b%b want v%b cr%b b%b",
                           c, out_valid, counter_reset, busy, ev, ecr, eb);
      end
      if (ev) begin
        n_vec++;
        if ({out_data, out_channel, out_last} !== {32'(10*(c-12)), 2'(c-13), (c == 16) ? 1'b1 : 1'b0}) begin
          n_miss++; $display("FAIL basic_beat c%0d got d%0d ch%0d l%b want d%0d ch%0d l%b",
                             c, out_data, out_channel, out_last, 10*(c-12), c-13, c == 16);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0, n_ch1 = 0, n_held = 0, hold = 0;
    bit stalled = 0, go_low;
    do_reset();
    counts_in = {32'd40, 32'd30, 32'd20, 32'd10};
    gate_periods = 32'd3;
    @(posedge clock); #1 start = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin n_acc++; if (out_channel == 2'd1) n_ch1++; end
      if (out_valid && !out_ready) begin
        n_held++; n_vec++;
        if ({out_channel, out_data} !== {2'd1, 32'd20}) begin
          n_miss++; $display("FAIL bp_hold got ch%0d d%0d want ch1 d20", out_channel, out_data);
        end
      end
      go_low = out_valid && (out_channel == 2'd0) && out_ready && !stalled;
      @(posedge clock); #1;
      start = 0;
      if (go_low) begin out_ready = 0; stalled = 1; hold = 3; end
      else if (hold > 0) begin hold--; if (hold == 0) out_ready = 1; end
    end
    n_vec++;
    if ({n_acc, n_ch1, n_held} !== {32'd4, 32'd1, 32'd3}) begin
      n_miss++; $display("FAIL bp_counts got beats%0d ch1:%0d held%0d want 4 1 3", n_acc, n_ch1, n_held);
    end
  endtask

  task automatic test_overrun();
    bit seen = 0;
    do_reset();
    counts_in = {32'd4, 32'd3, 32'd2, 32'd1};
    gate_periods = 32'd2; continuous = 1; out_ready = 0;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (overrun === 1'b1) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen || dropped_frames !== 16'd1) begin
      n_miss++; $display("FAIL overrun_first got ovr%b drop%0d want 1 1", overrun, dropped_frames);
    end
    for (int j = 2; j <= 4; j++) begin
      repeat (4) @(negedge clock);
      n_vec++;
      if ({dropped_frames, overrun, out_frame, out_valid, out_channel} !== {16'(j), 1'b1, 16'd0, 1'b1, 2'd0}) begin
        n_miss++; $display("FAIL overrun_step got drop%0d ovr%b f%0d v%b ch%0d want drop%0d 1 0 1 0",
                           dropped_frames, overrun, out_frame, out_valid, out_channel, j);
      end
    end
    send_stop();
    @(posedge clock); #1 out_ready = 1; continuous = 0;
    wait_idle(100);
  endtask

  task automatic test_zero_gate();
    int lat;
    for (int g = 0; g <= 1; g++) begin
      do_reset();
      gate_periods = 32'(g);
      pulse_start();
      lat = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (out_valid === 1'b1) break;
        @(posedge clock); #1 lat++;
      end
      n_vec++;
      if (lat !== 4) begin
        n_miss++; $display("FAIL zero_gate gp=%0d start-to-valid got %0d want 4", g, lat);
      end
      wait_idle(20);
    end
  endtask

  task automatic test_last_beat_snap();
    logic [15:0] exp_f = 16'd0;
    do_reset();
    counts_in = {32'hd, 32'hc, 32'hb, 32'ha};
    gate_periods = 32'd2; continuous = 1; out_ready = 1;
    pulse_start();
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      n_vec++;
      if (overrun !== 1'b0) begin n_miss++; $display("FAIL lbs_overrun got %b want 0", overrun); end
      if (out_valid && out_channel == 2'd0) begin
        n_vec++;
        if (out_frame !== exp_f) begin
          n_miss++; $display("FAIL lbs_frame got %0d want %0d", out_frame, exp_f);
        end
        exp_f++;
      end
      @(posedge clock); #1;
    end
    n_vec++;
    if (exp_f < 16'd4) begin n_miss++; $display("FAIL lbs_frames got %0d want >=4", exp_f); end
    send_stop();
    continuous = 0;
    wait_idle(60);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    counts_in = {32'd44, 32'd33, 32'd22, 32'd11};
    gate_periods = 32'd8;
    pulse_start();
    repeat (4) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    n_vec++;
    if ({counter_reset, busy, out_valid, overrun, dropped_frames, out_frame} !== {4'b1000, 32'd0}) begin
      n_miss++; $display("FAIL mid_gate_reset got cr%b b%b v%b o%b drop%0d f%0d want 1 0 0 0 0 0",
                         counter_reset, busy, out_valid, overrun, dropped_frames, out_frame);
    end
    repeat (12) begin
      @(negedge clock);
      n_vec++;
      if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_gate_quiet got v%b want 0", out_valid); end
    end
    gate_periods = 32'd1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid && out_channel == 2'd1) begin seen = 1; break; end
    end
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    n_vec++;
    if (!seen || {out_valid, busy, out_channel} !== 4'b0000) begin
      n_miss++; $display("FAIL mid_read_reset got seen%b v%b b%b ch%0d want 1 0 0 0",
                         seen, out_valid, busy, out_channel);
    end
    seen = 0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen || {out_frame, out_channel, out_data} !== {16'd0, 2'd0, 32'd11}) begin
      n_miss++; $display("FAIL post_reset_frame got seen%b f%0d ch%0d d%0d want 1 0 0 11",
                         seen, out_frame, out_channel, out_data);
    end
    wait_idle(20);
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      continuous   = 1'($urandom_range(0, 1));
      gate_periods = 32'($urandom_range(0, 6));
      if (continuous && gate_periods < 2) gate_periods = 32'd2;
      counts_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      pulse_start();
      len = $urandom_range(10, 40);
      for (int c = 0; c < len; c++) begin
        @(posedge clock); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 9) == 0);
        counts_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(posedge clock); #1 start = 0;
      if (continuous) send_stop();
      @(posedge clock); #1 out_ready = 1;
      wait_idle(200);
    end
    continuous = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_zero_gate();
    test_last_beat_snap();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/scaler_readout_sequencer.md
SCALER_READOUT_SEQUENCER -- requirements
Module: scaler_readout_sequencer

Interface
REQ-001 SHALL have parameter NUMBER_OF_CHANNELS, default 8: number of iserdes_counter channels sequenced.
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32: width of each channel count.
REQ-003 SHALL have parameter LOG2_OF_NUMBER_OF_CHANNELS, default $clog2(NUMBER_OF_CHANNELS): channel index width.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports clock, reset.
REQ-005 clock  input  1: sole clock; all state updates on its rising edge.
REQ-006 reset  input  1: synchronous active-high reset.
REQ-007 start  input  1: one-cycle pulse that begins acquisition; ignored unless gate FSM is IDLE.
REQ-008 continuous  input  1: sampled with start; 1 = re-arm gate automatically after each snapshot.
REQ-009 stop  input  1: pulse; clears the latched continuous flag; current gate completes normally.
REQ-010 gate_periods  input  32: gate length in clock cycles; sampled with start.
REQ-011 counts_in  input  NUMBER_OF_CHANNELS*REGISTER_WIDTH: flattened counter outputs; channel k at bits [k*W +: W].
REQ-012 counter_reset  output  1: drives reset of all channel counters.
REQ-013 out_data  output  REGISTER_WIDTH: count of channel currently presented.
REQ-014 out_channel  output  LOG2_OF_NUMBER_OF_CHANNELS: index of out_data.
REQ-015 out_frame  output  16: frame number of the presented snapshot.
REQ-016 out_last  output  1: high with out_valid for channel NUMBER_OF_CHANNELS-1.
REQ-017 out_valid  output  1 / out_ready  input  1: valid/ready stream handshake.
REQ-018 busy  output  1: high whenever gate FSM not IDLE or readout FSM not EMPTY.
REQ-019 overrun  output  1: sticky; snapshot dropped because readout still busy.
REQ-020 dropped_frames  output  16: count of dropped snapshots, saturating at 16'hffff.

Function
REQ-021 Gate FSM states IDLE, CLEAR, GATE, SNAP; transitions: IDLE->CLEAR on start; CLEAR->GATE after 1 cycle; GATE->SNAP after exactly max(gate_periods,1) cycles; SNAP->CLEAR if continuous flag set, else SNAP->IDLE.
REQ-022 counter_reset SHALL be 1 in IDLE and CLEAR, 0 in GATE and SNAP.
REQ-023 In SNAP, counts_in SHALL be loaded into shadow registers at the edge ending SNAP, provided readout FSM is EMPTY or its last beat is accepted in that same cycle.
REQ-024 Otherwise snapshot SHALL be discarded, overrun set to 1, dropped_frames incremented (saturating); shadow contents untouched.
REQ-025 Frame counter (16 bit, wraps ffff->0) SHALL increment on each shadow load; out_frame reports the value assigned to that load, first frame = 0.
REQ-026 Readout FSM states EMPTY, SEND; EMPTY->SEND on shadow load; SEND presents channels 0..N-1 in ascending order, one per accepted beat; SEND->EMPTY when out_last beat accepted (unless reloaded per REQ-023, then restarts at channel 0).
REQ-027 out_valid SHALL assert the cycle after shadow load (latency 1 from SNAP); beat accepted when out_valid & out_ready.
REQ-028 While out_valid & !out_ready, out_data, out_channel, out_frame, out_last SHALL hold stable.
REQ-029 Gating SHALL continue during readout (double buffered); readout never stalls the gate FSM.
REQ-030 start while not IDLE SHALL be ignored; stop in IDLE has no effect; start and stop in same cycle: start wins, continuous flag cleared.
REQ-031 Gate cycle counter SHALL be 32 bits, no wrap within a gate.

Reset
REQ-032 On reset: gate FSM IDLE, readout FSM EMPTY, counter_reset=1, out_valid=0, out_last=0, out_data=0, out_channel=0, out_frame=0, busy=0, overrun=0, dropped_frames=0, frame counter=0, continuous flag=0.
REQ-033 Reset asserted mid-gate or mid-readout SHALL abort immediately; outputs take REQ-032 values on the next cycle; no partial frame emitted afterwards.

Verification
REQ-034 N=4, counts_in={40,30,20,10} (ch3..ch0), gate_periods=10, out_ready=1, start at cycle 0 -> CLEAR c1, GATE c2-c11, SNAP c12, out_valid c13-c16 data 10,20,30,40, out_last at c16, busy low c17.
REQ-035 Backpressure: out_ready low for 3 cycles on channel 1 -> data 20/channel 1 held, no beats lost or duplicated.
REQ-036 continuous=1, gate_periods=2, out_ready=0 -> frame 0 loaded, next SNAP sets overrun=1, dropped_frames increments every 4 cycles, out_frame stays 0.
REQ-037 gate_periods=0 -> GATE lasts 1 cycle, identical to gate_periods=1.
REQ-038 Last beat accepted in same cycle as SNAP -> new frame loaded, out_frame increments, overrun stays 0.
REQ-039 Reset during GATE -> REQ-032 values next cycle; subsequent start yields normal frame 0.
